shuffle_stream_ctrl: RTL and testbench

- Streaming controller that wraps the combinational element shuffle with AXI-Stream handshakes and a double-buffered frame store.
- Accepts frames of FRAME_BEATS input beats. Emits each frame with beats reordered per BEAT_ORDER and elements permuted within each beat per ELEM_PERM.
- Sits between FINN dataflow layers wherever a static tensor reshuffle (transpose/reorder) is required.

---
 rtl/shuffle_pkg.sv | 32 +++
 rtl/shuffle_elem_perm.sv | 34 +++
 rtl/shuffle_stream_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_shuffle_stream_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shuffle_pkg.sv
// ---------------------------------------------------------------------------
// shuffle_pkg
// Shared definitions for the shuffle stream controller:
//   - clog2()       : constant ceil(log2) helper used to size counters and
//                     the packed permutation fields.
//   - bank_state_t  : lifecycle of one frame-store bank.
// No ports (package).
// ---------------------------------------------------------------------------
package shuffle_pkg;

   // Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   // ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/shuffle_elem_perm.sv
// ---------------------------------------------------------------------------
// shuffle_elem_perm
// Purely combinational element permutation within one beat.
// Output element i is input element ELEM_PERM[i*IW +: IW]; element j of a
// beat lives at bits [j*ELEM_W +: ELEM_W]. The permutation is fixed at
// elaboration time, so this is nothing more than wiring.
//
// Ports:
//   in0   in   ELEMS*ELEM_W   beat before permutation
//   out0  out  ELEMS*ELEM_W   beat after permutation
// ---------------------------------------------------------------------------
module shuffle_elem_perm
   import shuffle_pkg::*;
#(
   parameter int ELEM_W = 2,
   parameter int ELEMS  = 4,
   parameter logic [ELEMS*clog2(ELEMS)-1:0] ELEM_PERM = {2'd3, 2'd2, 2'd1, 2'd0}
) (
   input  logic [ELEMS*ELEM_W-1:0] in0,
   output logic [ELEMS*ELEM_W-1:0] out0
);

   localparam int IW = clog2(ELEMS);

   genvar gi;
   generate
      for (gi = 0; gi < ELEMS; gi++) begin : g_elem
         // Source index resolved at elaboration: no runtime mux is built.
         localparam int SRC = int'(ELEM_PERM[gi*IW +: IW]);
         assign out0[gi*ELEM_W +: ELEM_W] = in0[SRC*ELEM_W +: ELEM_W];
      end
   endgenerate

endmodule

// File: rtl/shuffle_stream_ctrl.sv
// ---------------------------------------------------------------------------
// shuffle_stream_ctrl
// AXI-Stream wrapper around a static tensor reshuffle. Frames of FRAME_BEATS
// beats are captured into one of two banks while the other bank drains, so
// fill and drain overlap and the stream sustains one beat per cycle.
// On drain, output beat k is input beat BEAT_ORDER[k*BW +: BW] of the frame,
// with its elements permuted by ELEM_PERM.
//
// Ports:
//   ap_clk        in   1             clock
//   ap_rst        in   1             asynchronous active-high reset
//   in0_V_TDATA   in   ELEMS*ELEM_W  input beat
//   in0_V_TVALID  in   1             input valid
//   in0_V_TREADY  out  1             input ready
//   in0_V_TLAST   in   1             producer end-of-frame marker (checked only)
//   out_V_TDATA   out  ELEMS*ELEM_W  shuffled output beat
//   out_V_TVALID  out  1             output valid
//   out_V_TREADY  in   1             downstream ready
//   out_V_TLAST   out  1             high on the last beat of each frame
//   frame_err     out  1             sticky in0_V_TLAST mismatch flag
// ---------------------------------------------------------------------------
module shuffle_stream_ctrl
   import shuffle_pkg::*;
#(
   parameter int ELEM_W      = 2,
   parameter int ELEMS       = 4,
   parameter int FRAME_BEATS = 4,
   parameter logic [FRAME_BEATS*clog2(FRAME_BEATS)-1:0] BEAT_ORDER = {2'd0, 2'd1, 2'd2, 2'd3},
   parameter logic [ELEMS*clog2(ELEMS)-1:0]             ELEM_PERM  = {2'd3, 2'd2, 2'd1, 2'd0}
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic [ELEMS*ELEM_W-1:0]  in0_V_TDATA,
   input  logic                     in0_V_TVALID,
   output logic                     in0_V_TREADY,
   input  logic                     in0_V_TLAST,
   output logic [ELEMS*ELEM_W-1:0]  out_V_TDATA,
   output logic                     out_V_TVALID,
   input  logic                     out_V_TREADY,
   output logic                     out_V_TLAST,
   output logic                     frame_err
);

   localparam int TW = ELEMS * ELEM_W;
   localparam int BW = clog2(FRAME_BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   bank_state_t       bank_state_reg  [2];
   bank_state_t       bank_state_next [2];
   logic              wr_bank_reg;
   logic [BW-1:0]     wr_cnt_reg;
   logic              rd_bank_reg;
   logic [BW-1:0]     rd_cnt_reg;
   logic [TW-1:0]     out_data_reg;
   logic              out_valid_reg;
   logic              out_last_reg;
   logic              frame_err_reg;

   // Frame store: plain registers, read asynchronously so the selected beat
   // can be permuted and captured into the output register in one cycle.
   logic [TW-1:0]     mem [2][FRAME_BEATS];

   // ------------------------------------------------------------------
   // Beat-order lookup, unpacked from the packed parameter
   // ------------------------------------------------------------------
   logic [BW-1:0]     order_lut [FRAME_BEATS];

   genvar gi;
   generate
      for (gi = 0; gi < FRAME_BEATS; gi++) begin : g_order
         assign order_lut[gi] = BEAT_ORDER[gi*BW +: BW];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   logic wr_open;
   logic wr_fire;
   logic wr_last;

   assign wr_open      = (bank_state_reg[wr_bank_reg] == EMPTY) ||
                         (bank_state_reg[wr_bank_reg] == FILLING);
   // Reset only gates the visible ready; all state is held in reset anyway.
   assign in0_V_TREADY = wr_open && !ap_rst;
   assign wr_fire      = in0_V_TVALID && wr_open;
   assign wr_last      = (wr_cnt_reg == LAST_BEAT);

   always_ff @(posedge ap_clk) begin
      if (wr_fire) begin
         mem[wr_bank_reg][wr_cnt_reg] <= in0_V_TDATA;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wr_bank_reg   <= 1'b0;
         wr_cnt_reg    <= '0;
         frame_err_reg <= 1'b0;
      end else if (wr_fire) begin
         wr_cnt_reg <= wr_cnt_reg + 1'b1;   // wraps to 0 after the last beat
         if (wr_last) begin
            wr_bank_reg <= ~wr_bank_reg;
         end
         // Framing is purely count based; TLAST is only cross-checked.
         if (in0_V_TLAST != wr_last) begin
            frame_err_reg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------
   logic          rd_avail;
   logic          rd_load;
   logic          rd_last;
   logic [TW-1:0] rd_beat;
   logic [TW-1:0] rd_shuf;

   assign rd_avail = (bank_state_reg[rd_bank_reg] == FULL) ||
                     (bank_state_reg[rd_bank_reg] == DRAINING);
   assign rd_load  = rd_avail && (!out_valid_reg || out_V_TREADY);
   assign rd_last  = (rd_cnt_reg == LAST_BEAT);
   assign rd_beat  = mem[rd_bank_reg][order_lut[rd_cnt_reg]];

   shuffle_elem_perm #(
      .ELEM_W    (ELEM_W),
      .ELEMS     (ELEMS),
      .ELEM_PERM (ELEM_PERM)
   ) u_elem_perm (
      .in0  (rd_beat),
      .out0 (rd_shuf)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         rd_bank_reg   <= 1'b0;
         rd_cnt_reg    <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else if (rd_load) begin
         out_data_reg  <= rd_shuf;
         out_last_reg  <= rd_last;
         out_valid_reg <= 1'b1;
         rd_cnt_reg    <= rd_cnt_reg + 1'b1;
         if (rd_last) begin
            rd_bank_reg <= ~rd_bank_reg;
         end
      end else if (out_V_TREADY) begin
         out_valid_reg <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Bank lifecycle. The writer only touches an EMPTY/FILLING bank and the
   // reader only a FULL/DRAINING one, so the two updates never collide even
   // when both pointers name the same bank.
   // ------------------------------------------------------------------
   always_comb begin
      bank_state_next = bank_state_reg;
      if (wr_fire) begin
         bank_state_next[wr_bank_reg] = wr_last ? FULL : FILLING;
      end
      if (rd_load) begin
         bank_state_next[rd_bank_reg] = rd_last ? EMPTY : DRAINING;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         bank_state_reg <= '{default: EMPTY};
      end else begin
         bank_state_reg <= bank_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign out_V_TDATA  = out_data_reg;
   assign out_V_TVALID = out_valid_reg;
   assign out_V_TLAST  = out_last_reg;
   assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_shuffle_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shuffle_stream_ctrl
// Two instances share clock, reset and input/ready stimulus:
//   dut    : default reverse beat order, reversed elements
//   dut_id : identity beat order and identity elements
// A scoreboard builds expected output beats whenever a frame completes on
// the input side and checks them as output handshakes occur.
// ---------------------------------------------------------------------------
module tb_shuffle_stream_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;

   logic       in_ready, id_in_ready;
   logic [7:0] out_data, id_out_data;
   logic       out_valid, id_out_valid;
   logic       out_last, id_out_last;
   logic       frame_err, id_frame_err;

   shuffle_stream_ctrl #(
      .ELEM_W(2), .ELEMS(4), .FRAME_BEATS(4),
      .BEAT_ORDER(8'h1B), .ELEM_PERM(8'h1B)
   ) dut (
      .ap_clk(clk), .ap_rst(rst),
      .in0_V_TDATA(in_data), .in0_V_TVALID(in_valid),
      .in0_V_TREADY(in_ready), .in0_V_TLAST(in_last),
      .out_V_TDATA(out_data), .out_V_TVALID(out_valid),
      .out_V_TREADY(out_ready), .out_V_TLAST(out_last),
      .frame_err(frame_err)
   );

   shuffle_stream_ctrl #(
      .ELEM_W(2), .ELEMS(4), .FRAME_BEATS(4),
      .BEAT_ORDER(8'hE4), .ELEM_PERM(8'hE4)
   ) dut_id (
      .ap_clk(clk), .ap_rst(rst),
      .in0_V_TDATA(in_data), .in0_V_TVALID(in_valid),
      .in0_V_TREADY(id_in_ready), .in0_V_TLAST(in_last),
      .out_V_TDATA(id_out_data), .out_V_TVALID(id_out_valid),
      .out_V_TREADY(out_ready), .out_V_TLAST(id_out_last),
      .frame_err(id_frame_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   exp_t id_q[$];
   exp_t e_main, e_id;
   logic [7:0] m_frame [4];
   int m_cnt       = 0;
   int cyc         = 0;
   int run_len     = 0;
   int last_hs_cyc = -10;

   typedef struct {
      logic [7:0] din;
      logic       lin;
      logic [7:0] dout;
      logic       lout;
   } vec_t;
   vec_t vecs[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Reference: output element i = input element 3-i.
   function automatic logic [7:0] rev_elems(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 4; i++) r[2*i +: 2] = d[2*(3-i) +: 2];
      return r;
   endfunction

   // Scoreboard / monitor: sampled mid-cycle, handshakes complete at the next edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         id_q.delete();
         m_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
               e_main = exp_q.pop_front();
               check("sb_data", out_data, e_main.data);
               check("sb_last", out_last, e_main.last);
            end
            run_len     = (cyc == last_hs_cyc + 1) ? run_len + 1 : 1;
            last_hs_cyc = cyc;
         end
         if (id_out_valid && out_ready) begin
            if (id_q.size() == 0) check("sb_id_unexpected", 1, 0);
            else begin
               e_id = id_q.pop_front();
               check("sb_id_data", id_out_data, e_id.data);
               check("sb_id_last", id_out_last, e_id.last);
            end
         end
         if (in_valid && in_ready) begin
            m_frame[m_cnt] = in_data;
            if (m_cnt == 3) begin
               for (int k = 0; k < 4; k++) begin
                  exp_q.push_back('{data: rev_elems(m_frame[3-k]), last: (k == 3)});
                  id_q.push_back('{data: m_frame[k], last: (k == 3)});
               end
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic drive_beat(input logic [7:0] d, input logic l, input int bound,
                             output bit ok, output int tries);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      ok       = 1'b0;
      tries    = 0;
      while (!ok && tries < bound) begin
         @(negedge clk);
         ok = in_ready;
         tries++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string name, input logic [7:0] d, input logic l);
      check({name, "_valid"}, out_valid, 1);
      check({name, "_data"}, out_data, d);
      check({name, "_last"}, out_last, l);
   endtask

   task automatic wait_drain(input int bound);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || id_q.size() != 0) && i < bound) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("drain_done", exp_q.size() + id_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      bit         stop;
      int         tries;
      int         acc;
      logic [7:0] rd;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

      vecs[0] = '{8'h1B, 1'b0, 8'h1B, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 8'hFF, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 8'h00, 1'b0};
      vecs[3] = '{8'hE4, 1'b1, 8'hE4, 1'b1};
      vecs[4] = '{8'h01, 1'b0, 8'h10, 1'b0};
      vecs[5] = '{8'h02, 1'b0, 8'hC0, 1'b0};
      vecs[6] = '{8'h03, 1'b0, 8'h80, 1'b0};
      vecs[7] = '{8'h04, 1'b1, 8'h40, 1'b1};

      // Reset state
      #1;
      check("rst_tready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      check("rst_err", frame_err, 0);
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_tready", in_ready, 1);

      // Table-driven frames, one output per cycle, 1-cycle post-frame latency
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 4; k++) begin
            drive_beat(vecs[f*4+k].din, vecs[f*4+k].lin, 8, ok, tries);
            check("t1_accept", ok, 1);
         end
         in_valid = 1'b0;
         check("t1_lat_early", out_valid, 0);
         check("t1_id_lat_early", id_out_valid, 0);
         @(posedge clk); #1;
         for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check_out("t1_out", vecs[f*4+k].dout, vecs[f*4+k].lout);
            check("t1_id_data", id_out_data, vecs[f*4+k].din);
         end
      end
      check("t1_err", frame_err, 0);
      wait_drain(10);

      // Three back-to-back frames: ready never drops, 12 consecutive outputs
      for (int b = 0; b < 12; b++) begin
         rd = 8'($urandom_range(0, 255));
         drive_beat(rd, (b % 4) == 3, 8, ok, tries);
         check("t2_tready", (ok && tries == 1), 1);
      end
      in_valid = 1'b0;
      wait_drain(20);
      check("t2_run", run_len, 12);

      // Backpressure: two frames fit, the rest stalls; output held stable
      out_ready = 1'b0;
      acc  = 0;
      stop = 1'b0;
      for (int b = 0; b < 10 && !stop; b++) begin
         drive_beat(vecs[b % 8].din, (b % 4) == 3, 4, ok, tries);
         if (ok) acc++;
         else stop = 1'b1;
      end
      in_valid = 1'b0;
      check("t3_accepted", acc, 8);
      check("t3_tready", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         check_out("t3_hold", 8'h1B, 1'b0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_drain(30);

      // TLAST on the wrong beat: sticky error, framing unaffected
      for (int k = 0; k < 4; k++) begin
         drive_beat(vecs[4+k].din, (k == 2), 8, ok, tries);
         if (k == 1) check("t4_err_before", frame_err, 0);
         if (k == 2) check("t4_err_set", frame_err, 1);
      end
      in_valid = 1'b0;
      wait_drain(20);
      check("t4_err_sticky", frame_err, 1);
      check("t4_id_err_sticky", id_frame_err, 1);

      // Async reset with a full frame pending and a partial frame in flight
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) drive_beat(8'h1B, (k == 3), 8, ok, tries);
      for (int k = 0; k < 2; k++) drive_beat(8'h55, 1'b0, 8, ok, tries);
      in_valid = 1'b0;
      check("t5_pre_valid", out_valid, 1);
      check("t5_pre_data", out_data, 8'hE4);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_tready", in_ready, 0);
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_data", out_data, 0);
      check("t5_rst_last", out_last, 0);
      check("t5_rst_err", frame_err, 0);
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) drive_beat(8'h1B, (k == 3), 8, ok, tries);
      in_valid = 1'b0;
      check("t5_lat_early", out_valid, 0);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         check_out("t5_out", 8'hE4, (k == 3));
         check("t5_id_data", id_out_data, 8'h1B);
      end
      wait_drain(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
